ifetch_ctrl: RTL

- Instruction-fetch sequencer between the PC logic and the synchronous 4 KB instruction memory (1-cycle registered read, raises an out-of-range exception flag).
- Owns the fetch PC and drives the memory read address.
- Tracks the one in-flight read and buffers returned words in a 2-entry queue toward the decoder, using a valid/ready handshake.
- Handles redirects from jump/branch resolution, and stops fetching on a memory exception until redirected.

---
 rtl/ifetch_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// It owns the fetch PC and drives the synchronous instruction memory address.
// It tracks the single in-flight read and buffers the returned words in a
// 2-entry FIFO toward the decoder, using a valid/ready handshake.
// A redirect flushes all fetched work. A memory exception halts fetch until
// the next redirect.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   im_addr           byte address to instruction memory (combinational)
//   im_instr, im_exp  read data and out-of-range flag, one cycle after address
//   redirect_valid/pc restart request from jump/branch resolution
//   out_valid/ready   handshake toward the decoder
//   out_instr/pc/exp  head entry of the output queue
//   stopped           fetch halted after an exception
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    input  logic        im_exp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_exp,
    output logic        stopped
);

    typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] req_pc_reg;
    logic        inflight_reg;
    logic [1:0]  count_reg;
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;

    logic [31:0] q_instr_reg [2];
    logic [31:0] q_pc_reg    [2];
    logic        q_exp_reg   [2];

    logic        pop;
    logic [2:0]  occ;
    logic        misaligned;
    logic        resp_exp;
    logic        issue;
    logic        enq;
    logic        wr_idx;
    logic [31:0] enq_instr;
    logic [31:0] enq_pc;
    logic        enq_exp;

    assign im_addr    = redirect_valid ? redirect_pc : fetch_pc_reg;
    assign out_valid  = (count_reg != 2'd0);
    assign pop        = out_valid & out_ready;
    // Occupancy as it will stand after this edge if nothing new is issued.
    // Because the in-flight word is counted, the FIFO can never overflow.
    assign occ        = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign resp_exp   = inflight_reg & im_exp;
    assign stopped    = (state_reg == STOP);

    // Outputs are zeroed while the queue is empty, so flushed entries stay invisible.
    assign out_instr  = out_valid ? q_instr_reg[rd_ptr_reg] : 32'h0;
    assign out_pc     = out_valid ? q_pc_reg[rd_ptr_reg]    : 32'h0;
    assign out_exp    = out_valid ? q_exp_reg[rd_ptr_reg]   : 1'b0;

    always_comb begin
        issue     = 1'b0;
        enq       = 1'b0;
        wr_idx    = wr_ptr_reg;
        enq_instr = 32'h0;
        enq_pc    = req_pc_reg;
        enq_exp   = 1'b0;
        if (redirect_valid) begin
            // Any returning response is dropped.
            // A misaligned target becomes an exception entry in the emptied queue.
            issue   = ~misaligned;
            enq     = misaligned;
            wr_idx  = 1'b0;
            enq_pc  = redirect_pc;
            enq_exp = 1'b1;
        end else begin
            // An exception response cancels the issue that would happen in the same cycle.
            issue     = (state_reg == RUN) && (occ < 3'(QDEPTH)) && !resp_exp;
            enq       = inflight_reg;
            enq_instr = im_exp ? 32'h0 : im_instr;
            enq_exp   = im_exp;
        end
    end

    // FIFO storage: one write port, per-entry enable.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (enq && (wr_idx == 1'(gi))) begin
                    q_instr_reg[gi] <= enq_instr;
                    q_pc_reg[gi]    <= enq_pc;
                    q_exp_reg[gi]   <= enq_exp;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_reg <= im_addr + 32'd4;
                req_pc_reg   <= im_addr;
            end
            inflight_reg <= issue;
            if (redirect_valid) begin
                // The head is flushed rather than consumed, even if out_ready is high.
                state_reg  <= misaligned ? STOP : RUN;
                count_reg  <= {1'b0, misaligned};
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= misaligned;
            end else begin
                if (resp_exp) begin
                    state_reg <= STOP;
                end
                count_reg  <= count_reg + {1'b0, enq} - {1'b0, pop};
                rd_ptr_reg <= rd_ptr_reg ^ pop;
                wr_ptr_reg <= wr_ptr_reg ^ enq;
            end
        end
    end

endmodule
